// File: rtl/vx_lmem_bank_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vx_lmem_bank_sched_pkg                                               |
// | Shared local-memory interleaving helpers and scheduler state type.   |
// | Bank select comes from the low word-address bits and the row from    |
// | the remaining upper bits, so every block that touches local memory   |
// | agrees on how addresses are interleaved.                             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package vx_lmem_bank_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_t;

  // The bank count must be a power of two and at least 2.
  function automatic int lmem_bank_sel_bits(input int num_banks);
    return $clog2(num_banks);
  endfunction

  function automatic int lmem_row_bits(input int addr_width, input int num_banks);
    return addr_width - lmem_bank_sel_bits(num_banks);
  endfunction

  function automatic logic [31:0] lmem_bank_sel(input logic [31:0] addr, input int sel_bits);
    return addr & ((32'd1 << sel_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] lmem_row(input logic [31:0] addr, input int sel_bits);
    return addr >> sel_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vx_lmem_bank_sched_conflict_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vx_lmem_bank_sched_conflict_pick                                     |
// | Combinational bank-conflict resolver for one scheduling pass.        |
// | Ports:                                                               |
// |   pending   - lanes still waiting for a bank access                  |
// |   rw        - 1 = write request                                      |
// |   addr      - per-lane word addresses                                |
// |   win_valid - per bank: some pending lane maps to this bank          |
// |   win_idx   - per bank: lowest-index pending lane on this bank       |
// |   served    - lanes completed by this pass (winners + read merges)   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vx_lmem_bank_sched_conflict_pick
  import vx_lmem_bank_sched_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int NUM_BANKS  = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int LANE_BITS  = 2
) (
  input  logic [NUM_LANES-1:0]            pending,
  input  logic                            rw,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0] addr,
  output logic [NUM_BANKS-1:0]            win_valid,
  output logic [NUM_BANKS*LANE_BITS-1:0]  win_idx,
  output logic [NUM_LANES-1:0]            served
);

  localparam int BANK_SEL_BITS = lmem_bank_sel_bits(NUM_BANKS);

  logic [ADDR_WIDTH-1:0]    lane_addr [NUM_LANES];
  logic [BANK_SEL_BITS-1:0] lane_bank [NUM_LANES];
  logic [LANE_BITS-1:0]     win_lane;

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign lane_addr[i] = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign lane_bank[i] = BANK_SEL_BITS'(lmem_bank_sel(32'(lane_addr[i]), BANK_SEL_BITS));
    end
  endgenerate

  // Scanning lanes from high to low lets the lowest-index match overwrite
  // the others, giving lowest-index priority without an early exit.
  always_comb begin
    win_valid = '0;
    win_idx   = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int l = NUM_LANES - 1; l >= 0; l--) begin
        if (pending[l] && (lane_bank[l] == BANK_SEL_BITS'(b))) begin
          win_valid[b]                      = 1'b1;
          win_idx[b*LANE_BITS +: LANE_BITS] = LANE_BITS'(l);
        end
      end
    end
  end

  // A pending lane always has a winner on its own bank. Reads sharing the
  // winner's exact address ride along; writes never merge so that later
  // lanes to the same word land after earlier ones.
  always_comb begin
    served   = '0;
    win_lane = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      win_lane = win_idx[int'(lane_bank[l])*LANE_BITS +: LANE_BITS];
      if (pending[l]) begin
        if (win_lane == LANE_BITS'(l)) begin
          served[l] = 1'b1;
        end else if (!rw && (lane_addr[win_lane] == lane_addr[l])) begin
          served[l] = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vx_lmem_bank_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vx_lmem_bank_sched                                                   |
// | Splits a warp-wide local-memory request into conflict-free bank      |
// | passes, merges same-address reads, and reassembles read data into a  |
// | single warp-wide response. Writes complete without a response.       |
// | Ports:                                                               |
// |   clk, reset           - clock, synchronous active-high reset        |
// |   req_*                - warp request (valid/ready handshake)        |
// |   rsp_*                - warp read response (valid/ready handshake)  |
// |   bank_req_*           - per-bank SRAM access, one pass per cycle    |
// |   bank_rsp_data        - per-bank read data, one cycle after access  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vx_lmem_bank_sched
  import vx_lmem_bank_sched_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int NUM_BANKS  = 4,
  parameter int WORD_SIZE  = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     req_valid,
  input  logic                                     req_rw,
  input  logic [NUM_LANES-1:0]                     req_mask,
  input  logic [NUM_LANES*WORD_SIZE-1:0]           req_byteen,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0]          req_addr,
  input  logic [NUM_LANES*WORD_SIZE*8-1:0]         req_data,
  input  logic [TAG_WIDTH-1:0]                     req_tag,
  output logic                                     req_ready,
  output logic                                     rsp_valid,
  output logic [NUM_LANES-1:0]                     rsp_mask,
  output logic [NUM_LANES*WORD_SIZE*8-1:0]         rsp_data,
  output logic [TAG_WIDTH-1:0]                     rsp_tag,
  input  logic                                     rsp_ready,
  output logic [NUM_BANKS-1:0]                     bank_req_valid,
  output logic [NUM_BANKS-1:0]                     bank_req_rw,
  output logic [NUM_BANKS*(ADDR_WIDTH-$clog2(NUM_BANKS))-1:0] bank_req_addr,
  output logic [NUM_BANKS*WORD_SIZE-1:0]           bank_req_byteen,
  output logic [NUM_BANKS*WORD_SIZE*8-1:0]         bank_req_data,
  input  logic [NUM_BANKS*WORD_SIZE*8-1:0]         bank_rsp_data
);

  localparam int BANK_SEL_BITS = lmem_bank_sel_bits(NUM_BANKS);
  localparam int ROW_BITS      = lmem_row_bits(ADDR_WIDTH, NUM_BANKS);
  localparam int WORD_BITS     = WORD_SIZE * 8;
  localparam int LANE_BITS     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  sched_state_t                     state;
  logic                             lat_rw;
  logic [NUM_LANES-1:0]             lat_mask;
  logic [NUM_LANES*WORD_SIZE-1:0]   lat_byteen;
  logic [NUM_LANES*ADDR_WIDTH-1:0]  lat_addr;
  logic [NUM_LANES*WORD_BITS-1:0]   lat_data;
  logic [TAG_WIDTH-1:0]             lat_tag;
  logic [NUM_LANES-1:0]             pending;
  logic [NUM_LANES-1:0]             cap_served;   // lanes whose bank data arrives this cycle

  logic [NUM_BANKS-1:0]             win_valid;
  logic [NUM_BANKS*LANE_BITS-1:0]   win_idx;
  logic [NUM_LANES-1:0]             served;
  logic [NUM_LANES-1:0]             remaining;
  logic [LANE_BITS-1:0]             sel_lane;

  logic [BANK_SEL_BITS-1:0]         lane_bank [NUM_LANES];
  logic [ROW_BITS-1:0]              lane_row  [NUM_LANES];

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane_decode
      assign lane_bank[i] = BANK_SEL_BITS'(lmem_bank_sel(32'(lat_addr[i*ADDR_WIDTH +: ADDR_WIDTH]), BANK_SEL_BITS));
      assign lane_row[i]  = ROW_BITS'(lmem_row(32'(lat_addr[i*ADDR_WIDTH +: ADDR_WIDTH]), BANK_SEL_BITS));
    end
  endgenerate

  vx_lmem_bank_sched_conflict_pick #(
    .NUM_LANES  (NUM_LANES),
    .NUM_BANKS  (NUM_BANKS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .LANE_BITS  (LANE_BITS)
  ) u_pick (
    .pending   (pending),
    .rw        (lat_rw),
    .addr      (lat_addr),
    .win_valid (win_valid),
    .win_idx   (win_idx),
    .served    (served)
  );

  assign remaining = pending & ~served;
  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign rsp_mask  = lat_mask;
  assign rsp_tag   = lat_tag;

  // Bank drive: only during ISSUE, and only for banks that have a winner.
  always_comb begin
    bank_req_valid  = '0;
    bank_req_rw     = '0;
    bank_req_addr   = '0;
    bank_req_byteen = '0;
    bank_req_data   = '0;
    sel_lane        = '0;
    if (state == ST_ISSUE) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (win_valid[b]) begin
          sel_lane                                   = win_idx[b*LANE_BITS +: LANE_BITS];
          bank_req_valid[b]                          = 1'b1;
          bank_req_rw[b]                             = lat_rw;
          bank_req_addr[b*ROW_BITS +: ROW_BITS]      = lane_row[sel_lane];
          bank_req_byteen[b*WORD_SIZE +: WORD_SIZE]  = lat_byteen[sel_lane*WORD_SIZE +: WORD_SIZE];
          bank_req_data[b*WORD_BITS +: WORD_BITS]    = lat_data[sel_lane*WORD_BITS +: WORD_BITS];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      lat_rw     <= 1'b0;
      lat_mask   <= '0;
      lat_byteen <= '0;
      lat_addr   <= '0;
      lat_data   <= '0;
      lat_tag    <= '0;
      pending    <= '0;
      cap_served <= '0;
      rsp_data   <= '0;
    end else begin
      // Read data of pass k is captured while pass k+1 issues; merged lanes
      // share an address, so each lane reads its own bank.
      cap_served <= (state == ST_ISSUE && !lat_rw) ? served : '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        if (cap_served[l]) begin
          rsp_data[l*WORD_BITS +: WORD_BITS] <= bank_rsp_data[lane_bank[l]*WORD_BITS +: WORD_BITS];
        end
      end

      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_rw     <= req_rw;
            lat_mask   <= req_mask;
            lat_byteen <= req_byteen;
            lat_addr   <= req_addr;
            lat_data   <= req_data;
            lat_tag    <= req_tag;
            pending    <= req_mask;
            rsp_data   <= '0;     // inactive lanes must read back as zero
            if (req_mask != '0) begin
              state <= ST_ISSUE;
            end else if (!req_rw) begin
              state <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          pending <= remaining;
          if (remaining == '0) begin
            state <= lat_rw ? ST_IDLE : ST_DRAIN;
          end
        end
        ST_DRAIN: state <= ST_RESP;
        ST_RESP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vx_lmem_bank_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vx_lmem_bank_sched                                                |
// | Self-checking bench: directed vector table, mid-issue reset, and     |
// | randomized requests against a flat-memory reference model.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_vx_lmem_bank_sched;

  localparam int NL = 4, NB = 4, WS = 4, AW = 12, TW = 8, RB = 10, WB = 32;

  logic                clk = 1'b0;
  logic                reset;
  logic                req_valid, req_rw, req_ready;
  logic [NL-1:0]       req_mask;
  logic [NL*WS-1:0]    req_byteen;
  logic [NL*AW-1:0]    req_addr;
  logic [NL*WB-1:0]    req_data;
  logic [TW-1:0]       req_tag;
  logic                rsp_valid, rsp_ready;
  logic [NL-1:0]       rsp_mask;
  logic [NL*WB-1:0]    rsp_data;
  logic [TW-1:0]       rsp_tag;
  logic [NB-1:0]       bank_req_valid, bank_req_rw;
  logic [NB*RB-1:0]    bank_req_addr;
  logic [NB*WS-1:0]    bank_req_byteen;
  logic [NB*WB-1:0]    bank_req_data;
  logic [NB*WB-1:0]    bank_rsp_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vx_lmem_bank_sched #(
    .NUM_LANES(NL), .NUM_BANKS(NB), .WORD_SIZE(WS), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw), .req_mask(req_mask), .req_byteen(req_byteen),
    .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_mask(rsp_mask), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_ready(rsp_ready),
    .bank_req_valid(bank_req_valid), .bank_req_rw(bank_req_rw), .bank_req_addr(bank_req_addr),
    .bank_req_byteen(bank_req_byteen), .bank_req_data(bank_req_data), .bank_rsp_data(bank_rsp_data)
  );

  function automatic logic [WB-1:0] w(input int a);
    return 32'(a) * 32'h0001_0101 + 32'hC0DE_0000;
  endfunction

  // ---------------- banked SRAM environment ----------------
  logic [WB-1:0] sram [NB][1<<RB];
  logic [WB-1:0] sram_rsp [NB];
  logic [WB-1:0] sram_tmp;
  logic          sram_init_done = 1'b0;

  always @(posedge clk) begin
    if (!sram_init_done) begin
      for (int a = 0; a < (1 << AW); a++) sram[a % NB][a / NB] <= w(a);
      for (int b = 0; b < NB; b++) sram_rsp[b] <= '0;
      sram_init_done <= 1'b1;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (bank_req_valid[b]) begin
          sram_tmp = sram[b][bank_req_addr[b*RB +: RB]];
          if (bank_req_rw[b]) begin
            for (int y = 0; y < WS; y++)
              if (bank_req_byteen[b*WS + y]) sram_tmp[y*8 +: 8] = bank_req_data[b*WB + y*8 +: 8];
            sram[b][bank_req_addr[b*RB +: RB]] <= sram_tmp;
          end else begin
            sram_rsp[b] <= sram_tmp;
          end
        end
      end
    end
  end

  generate
    for (genvar b = 0; b < NB; b++) begin : g_rsp
      assign bank_rsp_data[b*WB +: WB] = sram_rsp[b];
    end
  endgenerate

  // ---------------- reference model ----------------
  logic [WB-1:0] ref_mem [1<<AW];

  // Passes = largest number of distinct accesses any single bank must serve:
  // distinct addresses for reads, every active lane for writes.
  function automatic int model_passes(input bit rw, input bit [NL-1:0] mask, input bit [NL*AW-1:0] addr);
    int cnt [NB];
    int best;
    bit dup;
    best = 0;
    for (int b = 0; b < NB; b++) cnt[b] = 0;
    for (int l = 0; l < NL; l++) begin
      if (mask[l]) begin
        dup = 1'b0;
        if (!rw)
          for (int j = 0; j < l; j++)
            if (mask[j] && addr[j*AW +: AW] == addr[l*AW +: AW]) dup = 1'b1;
        if (!dup) cnt[addr[l*AW +: AW] % NB]++;
      end
    end
    for (int b = 0; b < NB; b++) if (cnt[b] > best) best = cnt[b];
    return best;
  endfunction

  function automatic bit [NL*WB-1:0] model_read(input bit [NL-1:0] mask, input bit [NL*AW-1:0] addr);
    bit [NL*WB-1:0] r;
    r = '0;
    for (int l = 0; l < NL; l++) if (mask[l]) r[l*WB +: WB] = ref_mem[addr[l*AW +: AW]];
    return r;
  endfunction

  task automatic model_write(input bit [NL-1:0] mask, input bit [NL*AW-1:0] addr,
                             input bit [NL*WB-1:0] data, input bit [NL*WS-1:0] be);
    for (int l = 0; l < NL; l++)
      if (mask[l])
        for (int y = 0; y < WS; y++)
          if (be[l*WS + y]) ref_mem[addr[l*AW +: AW]][y*8 +: 8] = data[l*WB + y*8 +: 8];
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit [NL*AW-1:0] pa(input int a0, input int a1, input int a2, input int a3);
    return {12'(a3), 12'(a2), 12'(a1), 12'(a0)};
  endfunction

  function automatic bit [NL*WB-1:0] pd(input logic [31:0] d0, input logic [31:0] d1,
                                         input logic [31:0] d2, input logic [31:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  // One full transaction: issue, count passes, check latency and response,
  // optionally hold backpressure, then consume.
  task automatic run_req(input string name, input bit rw, input bit [NL-1:0] mask,
                         input bit [NL*AW-1:0] addr, input bit [NL*WB-1:0] data,
                         input bit [NL*WS-1:0] be, input bit [TW-1:0] tag,
                         input int exp_k, input bit [NL*WB-1:0] exp_rd, input int hold);
    int n, passes, last_pass, exp_n;
    bit done, idle_bad, hold_bad;
    logic [NL*WB-1:0] held;
    @(negedge clk);
    chk({name, "_ready_in"}, req_ready, 1);
    req_valid = 1'b1; req_rw = rw; req_mask = mask; req_addr = addr;
    req_data = data; req_byteen = be; req_tag = tag;
    @(negedge clk);
    req_valid = 1'b0;
    req_mask  = 4'($urandom);
    if (rw) model_write(mask, addr, data, be);
    passes = 0; last_pass = 0; done = 1'b0; idle_bad = 1'b0; n = 1;
    while (!done && n <= 24) begin
      for (int b = 0; b < NB; b++)
        if (!bank_req_valid[b] && (bank_req_rw[b] || bank_req_addr[b*RB +: RB] != 0 ||
            bank_req_byteen[b*WS +: WS] != 0 || bank_req_data[b*WB +: WB] != 0)) idle_bad = 1'b1;
      if (|bank_req_valid) begin passes++; last_pass = n; end
      if (rw) begin
        if (rsp_valid) idle_bad = 1'b1;
        if (req_ready) done = 1'b1;
      end else if (rsp_valid) begin
        done = 1'b1;
      end
      if (!done) begin @(negedge clk); n++; end
    end
    chk({name, "_bank_idle_zero"}, idle_bad, 0);
    if (!done) begin
      chk({name, "_timeout"}, 0, 1);
    end else begin
      exp_n = rw ? exp_k + 1 : ((exp_k == 0) ? 1 : exp_k + 2);
      chk({name, "_passes"}, passes, exp_k);
      chk({name, "_last_pass"}, last_pass, exp_k);
      chk({name, "_latency"}, n, exp_n);
      if (!rw) begin
        chk({name, "_rsp_data"}, rsp_data, exp_rd);
        chk({name, "_rsp_mask"}, rsp_mask, mask);
        chk({name, "_rsp_tag"}, rsp_tag, tag);
        held = rsp_data; hold_bad = 1'b0;
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          if (!rsp_valid || rsp_data !== held || rsp_tag !== tag || rsp_mask !== mask ||
              bank_req_valid != 0 || req_ready) hold_bad = 1'b1;
        end
        if (hold > 0) chk({name, "_hold_stable"}, hold_bad, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({name, "_ready_after"}, {rsp_valid, req_ready}, 2'b01);
      end
    end
  endtask

  typedef struct {
    bit             rw;
    bit [NL-1:0]    mask;
    bit [NL*AW-1:0] addr;
    bit [NL*WB-1:0] data;
    bit [NL*WS-1:0] be;
    bit [TW-1:0]    tag;
    int             k;
    bit [NL*WB-1:0] rd;
    int             hold;
  } vec_t;

  function automatic vec_t mk(input bit rw, input bit [NL-1:0] mask, input bit [NL*AW-1:0] addr,
                              input bit [NL*WB-1:0] data, input bit [NL*WS-1:0] be,
                              input bit [TW-1:0] tag, input int k, input bit [NL*WB-1:0] rd,
                              input int hold);
    vec_t v;
    v.rw = rw; v.mask = mask; v.addr = addr; v.data = data; v.be = be;
    v.tag = tag; v.k = k; v.rd = rd; v.hold = hold;
    return v;
  endfunction

  vec_t vecs [12];
  logic [WB-1:0] w9m;

  initial begin
    bit rw_r;
    bit [NL-1:0] m_r;
    bit [NL*AW-1:0] a_r;
    bit [NL*WB-1:0] d_r;

    for (int a = 0; a < (1 << AW); a++) ref_mem[a] = w(a);
    w9m = {w(9)[31:24], 8'h22, w(9)[15:8], 8'h44};

    vecs[0]  = mk(0, 4'hF, pa(0,1,2,3),    '0, 16'hFFFF, 8'h11, 1, pd(w(0),w(1),w(2),w(3)), 0);
    vecs[1]  = mk(0, 4'hF, pa(0,4,8,12),   '0, 16'hFFFF, 8'h22, 4, pd(w(0),w(4),w(8),w(12)), 0);
    vecs[2]  = mk(0, 4'hF, pa(5,5,5,5),    '0, 16'hFFFF, 8'h33, 1, pd(w(5),w(5),w(5),w(5)), 0);
    vecs[3]  = mk(1, 4'b0101, pa(7,7,7,7), pd(32'hAAAA_AAAA, 32'h1111_1111, 32'hBBBB_BBBB, 32'h2222_2222),
                  16'hFFFF, 8'h44, 2, '0, 0);
    vecs[4]  = mk(0, 4'hF, pa(7,7,7,7),    '0, 16'hFFFF, 8'h55, 1,
                  pd(32'hBBBB_BBBB, 32'hBBBB_BBBB, 32'hBBBB_BBBB, 32'hBBBB_BBBB), 0);
    vecs[5]  = mk(0, 4'b0101, pa(16,99,18,99), '0, 16'hFFFF, 8'h66, 1, pd(w(16), 0, w(18), 0), 5);
    vecs[6]  = mk(0, 4'b0000, pa(3,3,3,3), '0, 16'hFFFF, 8'h77, 0, '0, 0);
    vecs[7]  = mk(1, 4'b0000, pa(3,3,3,3), pd(1,2,3,4), 16'hFFFF, 8'h88, 0, '0, 0);
    vecs[8]  = mk(1, 4'b0010, pa(0,9,0,0), pd(0, 32'h1122_3344, 0, 0), 16'h0050, 8'h89, 1, '0, 0);
    vecs[9]  = mk(0, 4'hF, pa(1,5,1,9),    '0, 16'hFFFF, 8'h99, 3, pd(w(1),w(5),w(1),w9m), 0);
    vecs[10] = mk(1, 4'hF, pa(2,6,2,3),    pd(32'hD0D0_D0D0, 32'hD1D1_D1D1, 32'hD2D2_D2D2, 32'hD3D3_D3D3),
                  16'hFFFF, 8'hAA, 3, '0, 0);
    vecs[11] = mk(0, 4'hF, pa(2,6,3,2),    '0, 16'hFFFF, 8'hBB, 2,
                  pd(32'hD2D2_D2D2, 32'hD1D1_D1D1, 32'hD3D3_D3D3, 32'hD2D2_D2D2), 1);

    reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_mask = '0; req_byteen = '0;
    req_addr = '0; req_data = '0; req_tag = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_bank_valid", bank_req_valid, 0);
    chk("reset_rsp_fields", {rsp_mask, rsp_tag, rsp_data}, 0);
    reset = 1'b0;

    foreach (vecs[i])
      run_req($sformatf("vec%0d", i), vecs[i].rw, vecs[i].mask, vecs[i].addr, vecs[i].data,
              vecs[i].be, vecs[i].tag, vecs[i].k, vecs[i].rd, vecs[i].hold);

    // Reset in the middle of a four-pass read.
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b0; req_mask = 4'hF; req_addr = pa(0,4,8,12); req_tag = 8'hEE;
    @(negedge clk);            // T+1: first pass
    req_valid = 1'b0;
    @(negedge clk);            // T+2: still issuing
    chk("midrst_issuing", |bank_req_valid, 1);
    reset = 1'b1;
    @(negedge clk);            // T+3
    chk("midrst_bank_valid", bank_req_valid, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_rsp_fields", {rsp_mask, rsp_tag, rsp_data}, 0);
    reset = 1'b0;
    run_req("after_rst", 0, 4'hF, pa(0,4,8,12), '0, 16'hFFFF, 8'h5C,
            4, model_read(4'hF, pa(0,4,8,12)), 0);

    for (int t = 0; t < 40; t++) begin
      rw_r = ($urandom_range(0, 9) < 3);
      m_r  = 4'($urandom);
      for (int l = 0; l < NL; l++) a_r[l*AW +: AW] = 12'($urandom_range(0, 31));
      for (int l = 0; l < NL; l++) d_r[l*WB +: WB] = $urandom;
      run_req($sformatf("rnd%0d", t), rw_r, m_r, a_r, d_r, 16'($urandom), 8'($urandom),
              model_passes(rw_r, m_r, a_r), model_read(m_r, a_r), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vx_lmem_bank_sched.md
Name: VX_lmem_bank_sched

Overview:
- Sits between the LSU local-request path (one warp-wide request per handshake) and a banked local-memory SRAM array.
- Converts each warp request into one or more bank passes. In each pass, every bank serves at most one lane address.
- Merges same-address reads across lanes.
- For reads, reassembles the per-lane data and returns a single warp-wide response carrying the original tag. Writes complete silently.

Parameters:
- NUM_LANES, 4, lanes per request
- NUM_BANKS, 4, SRAM banks (power of 2, ≤ NUM_LANES·4)
- WORD_SIZE, 4, bytes per lane word
- ADDR_WIDTH, 12, lane word-address width
- TAG_WIDTH, 8, request tag width
- Derived: BANK_SEL_BITS = log2(NUM_BANKS); ROW_BITS = ADDR_WIDTH − BANK_SEL_BITS

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request valid
- req_rw  in  1  1 = write
- req_mask  in  NUM_LANES  active lanes
- req_byteen  in  NUM_LANES·WORD_SIZE  per-lane byte enables
- req_addr  in  NUM_LANES·ADDR_WIDTH  per-lane word addresses
- req_data  in  NUM_LANES·WORD_SIZE·8  write data
- req_tag  in  TAG_WIDTH  request tag
- req_ready  out  1  request accepted when valid && ready
- rsp_valid  out  1  read response valid
- rsp_mask  out  NUM_LANES  copy of the read request mask
- rsp_data  out  NUM_LANES·WORD_SIZE·8  read data, zero for inactive lanes
- rsp_tag  out  TAG_WIDTH  tag of the read request
- rsp_ready  in  1  response consumed
- bank_req_valid  out  NUM_BANKS  bank access this cycle
- bank_req_rw  out  NUM_BANKS  1 = write
- bank_req_addr  out  NUM_BANKS·ROW_BITS  row address
- bank_req_byteen  out  NUM_BANKS·WORD_SIZE  byte enables
- bank_req_data  out  NUM_BANKS·WORD_SIZE·8  write data
- bank_rsp_data  in  NUM_BANKS·WORD_SIZE·8  read data, valid exactly 1 cycle after a read bank_req_valid

Behaviour:
- Clocking: single clock domain clk; reset synchronous active-high.
- Address decode:
  - Bank index = addr[BANK_SEL_BITS-1:0].
  - Row = addr[ADDR_WIDTH-1:BANK_SEL_BITS].
- FSM states: IDLE, ISSUE, DRAIN, RESP.
  - IDLE: req_ready=1. On handshake, latch all request fields and set pending = req_mask.
    - If pending≠0, go to ISSUE.
    - Else if read, go to RESP.
    - Else (write) stay in IDLE.
  - ISSUE: one pass per cycle.
    - For each bank b, the winner is the lowest-index pending lane mapped to b. Drive bank b with the winner's row, byteen and data.
    - Read: every pending lane with an address identical to the winner's is also served in this pass.
    - Write: only the winner is served, so a later lane's write to the same address lands last.
    - Served lanes are cleared from pending. The served-lane set and winner index per bank are registered for data capture.
    - When pending becomes 0: a read goes to DRAIN; a write goes to IDLE.
  - DRAIN: one cycle; capture bank_rsp_data of the last pass; then RESP.
  - Capture rule: the capture for pass k happens in the cycle after pass k, overlapped with pass k+1.
  - RESP: rsp_valid=1 with fields held stable; on rsp_ready, go to IDLE.
- req_ready is 0 in ISSUE, DRAIN and RESP (one request in flight).
- Latency, request accepted in cycle T:
  - Read with k passes: pass 1 at T+1, rsp_valid first asserted at T+k+2.
  - Write with k passes: last bank write at T+k; req_ready=1 again at T+k+1.
  - Zero-mask read: rsp_valid at T+1 with mask 0 and data 0.
  - Zero-mask write: no bank activity; ready at T+1.
- Pass count bounds: ≥1 (non-zero mask), ≤ popcount(mask), = max lanes per bank after read merging.
- Inactive lanes: never drive banks; their rsp_data words are 0.
- Idle banks: bank_req_valid=0 and all other bank fields 0 in any cycle with no winner.
- Reset (including mid-operation):
  - Next state IDLE; in-flight request dropped; pending cleared.
  - Outputs: req_ready=1; rsp_valid=0; rsp_mask/rsp_data/rsp_tag=0; bank_req_* = 0.
  - A partially issued write is not rolled back.
- Backpressure: while in RESP, rsp_* outputs are held and no bank activity occurs.

Decomposition:
- Shared package (VX_gpu_pkg): lmem_bank_sel/row extraction functions and the BANK_SEL_BITS/ROW_BITS derivation, so the LSU and local-memory blocks agree on interleaving.
- Sub-module VX_lmem_conflict_pick: purely combinational.
  - Inputs: pending, rw, addresses.
  - Outputs: per-bank winner valid/index, and the served-lane mask (including read merges).
- The top level holds the FSM, request latches, capture path and response register.

Test Plan:
- Conflict-free read: lanes 0-3 at addresses 0,1,2,3, all mask bits set → one pass with banks 0-3 valid at T+1; rsp_valid at T+3 with data = SRAM words 0..3 and tag echoed.
- Full conflict read: addresses 0,4,8,12 → 4 passes on bank 0 (rows 0,1,2,3); rsp_valid at T+6 with lane data correctly ordered.
- Broadcast read: all lanes read address 5 → single pass with only bank 1 valid, row 1; all 4 lanes return the same word at T+3.
- Same-address write: lane 0 writes 0xAAAA_AAAA and lane 2 writes 0xBBBB_BBBB to address 7 → passes at T+1 (lane 0) and T+2 (lane 2); a subsequent read of address 7 returns 0xBBBB_BBBB; no rsp_valid for the write; req_ready high at T+3.
- Backpressure and partial mask: read with mask 0b0101 and rsp_ready low for 5 cycles → rsp held stable; rsp_mask=0b0101; lanes 1 and 3 data = 0; next request accepted in the cycle after the handshake.
- Reset mid-ISSUE during a 4-pass read: reset asserted at T+2 → next cycle all bank_req_valid=0, rsp_valid=0, req_ready=1; a new read then completes normally.
